// File: rtl/serial_tx_if.sv
// Command-processor to UART transmitter handshake: request, byte, busy and done.
interface serial_tx_if;
    logic       txStart;
    logic [7:0] txData;
    logic       txBusy;
    logic       txDone;

    modport master (output txStart, output txData, input txBusy, input txDone);
    modport slave  (input txStart, input txData, output txBusy, output txDone);
endinterface

// File: rtl/serial_tx.sv
// Byte-wide UART transmitter: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
module serial_tx #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic        clk,
    input  logic        reset,
    serial_tx_if.slave  bus,
    output logic        txd
);

    localparam int unsigned CNT_W = 16;
    localparam int unsigned BIT_W = 3;

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   baud_cnt, baud_n;
    logic [BIT_W-1:0]   bit_cnt, bit_n;
    logic               stop_cnt, stop_n;
    logic [7:0]         shift, shift_n;
    logic               par_bit, par_n;
    logic               txd_n;
    logic               busy_q, busy_n;
    logic               done_q, done_n;
    logic               bit_end;
    logic               load;

    assign bus.txBusy = busy_q;
    assign bus.txDone = done_q;
    assign bit_end    = (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));

    // State and datapath registers; txd is registered from the next-state decode.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            shift    <= '0;
            par_bit  <= 1'b0;
            txd      <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_n;
            bit_cnt  <= bit_n;
            stop_cnt <= stop_n;
            shift    <= shift_n;
            par_bit  <= par_n;
            txd      <= txd_n;
            busy_q   <= busy_n;
            done_q   <= done_n;
        end
    end

    // Next-state, bit timing and line level; a request at the final stop edge chains straight into a new start bit.
    always_comb begin
        state_n = state;
        baud_n  = baud_cnt;
        bit_n   = bit_cnt;
        stop_n  = stop_cnt;
        shift_n = shift;
        par_n   = par_bit;
        txd_n   = 1'b1;
        busy_n  = busy_q;
        done_n  = 1'b0;
        load    = 1'b0;

        case (state)
            IDLE: begin
                baud_n = '0;
                busy_n = 1'b0;
                load   = bus.txStart;
            end
            START: begin
                txd_n = 1'b0;
                if (bit_end) begin
                    baud_n  = '0;
                    state_n = DATA;
                    txd_n   = shift[0];
                end else begin
                    baud_n = baud_cnt + CNT_W'(1);
                end
            end
            DATA: begin
                txd_n = shift[0];
                if (bit_end) begin
                    baud_n  = '0;
                    shift_n = {1'b0, shift[7:1]};
                    if (bit_cnt == BIT_W'(7)) begin
                        bit_n = '0;
                        if (PARITY != 0) begin
                            state_n = PAR;
                            txd_n   = par_bit;
                        end else begin
                            state_n = STOP;
                            txd_n   = 1'b1;
                        end
                    end else begin
                        bit_n = bit_cnt + BIT_W'(1);
                        txd_n = shift[1];
                    end
                end else begin
                    baud_n = baud_cnt + CNT_W'(1);
                end
            end
            PAR: begin
                txd_n = par_bit;
                if (bit_end) begin
                    baud_n  = '0;
                    state_n = STOP;
                    txd_n   = 1'b1;
                end else begin
                    baud_n = baud_cnt + CNT_W'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    baud_n = '0;
                    if (stop_cnt == 1'(STOP_BITS - 1)) begin
                        done_n  = 1'b1;
                        busy_n  = 1'b0;
                        state_n = IDLE;
                        load    = bus.txStart;
                    end else begin
                        stop_n = stop_cnt + 1'b1;
                    end
                end else begin
                    baud_n = baud_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (load) begin
            state_n = START;
            shift_n = bus.txData;
            par_n   = (PARITY == 1) ? ~(^bus.txData) : (^bus.txData);
            busy_n  = 1'b1;
            baud_n  = '0;
            bit_n   = '0;
            stop_n  = 1'b0;
            txd_n   = 1'b0;
        end
    end

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: three parity/stop configurations checked cycle by cycle against a frame model.
module tb_serial_tx;

    localparam int CPB = 4;
    localparam int PAR_OF  [3] = '{0, 1, 2};
    localparam int STOP_OF [3] = '{1, 2, 1};

    logic       clk = 1'b0;
    logic       reset;
    logic       start [3];
    logic [7:0] data  [3];
    logic       busy  [3];
    logic       done  [3];
    logic       txd_o [3];

    int errors = 0;
    int checks = 0;

    serial_tx_if bus0 ();
    serial_tx_if bus1 ();
    serial_tx_if bus2 ();

    assign bus0.txStart = start[0];
    assign bus0.txData  = data[0];
    assign bus1.txStart = start[1];
    assign bus1.txData  = data[1];
    assign bus2.txStart = start[2];
    assign bus2.txData  = data[2];
    assign busy[0] = bus0.txBusy;
    assign busy[1] = bus1.txBusy;
    assign busy[2] = bus2.txBusy;
    assign done[0] = bus0.txDone;
    assign done[1] = bus1.txDone;
    assign done[2] = bus2.txDone;

    serial_tx #(.CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1)) u0 (.clk(clk), .reset(reset), .bus(bus0), .txd(txd_o[0]));
    serial_tx #(.CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(2)) u1 (.clk(clk), .reset(reset), .bus(bus1), .txd(txd_o[1]));
    serial_tx #(.CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(1)) u2 (.clk(clk), .reset(reset), .bus(bus2), .txd(txd_o[2]));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int idx, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[u%0d] observed=%b expected=%b", tag, idx, obs, exp);
        end
    endtask

    function automatic int flen(input int idx);
        return CPB * (10 + ((PAR_OF[idx] != 0) ? 1 : 0) + (STOP_OF[idx] - 1));
    endfunction

    // Line level c cycles into a frame: bit slot k = c / CPB.
    function automatic logic exp_txd(input logic [7:0] b, input int par, input int c);
        int k;
        int ones;
        k = c / CPB;
        ones = $countones(b);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (k == 9 && par != 0) return (par == 1) ? ((ones % 2) == 0) : ((ones % 2) == 1);
        return 1'b1;
    endfunction

    task automatic check_idle(input string tag, input int idx);
        chk({tag, "_txd"}, idx, txd_o[idx], 1'b1);
        chk({tag, "_busy"}, idx, busy[idx], 1'b0);
        chk({tag, "_done"}, idx, done[idx], 1'b0);
    endtask

    // Called at a negedge; returns at the negedge of the first cycle after acceptance.
    task automatic send(input int idx, input logic [7:0] b);
        start[idx] = 1'b1;
        data[idx]  = b;
        @(negedge clk);
        start[idx] = 1'b0;
        data[idx]  = 8'($urandom);
    endtask

    task automatic expect_frame(input int idx, input logic [7:0] b, input bit mutate,
                                input bit intrude, input logic [7:0] intr_data, input bit chained);
        int len;
        len = flen(idx);
        for (int c = 0; c < len; c++) begin
            chk("txd", idx, txd_o[idx], exp_txd(b, PAR_OF[idx], c));
            chk("busy", idx, busy[idx], 1'b1);
            chk("done", idx, done[idx], (chained && c == 0) ? 1'b1 : 1'b0);
            if (mutate) data[idx] = 8'($urandom);
            if (intrude && c == len / 2) begin
                start[idx] = 1'b1;
                data[idx]  = intr_data;
            end else if (intrude && c == len / 2 + 1) begin
                start[idx] = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    task automatic end_idle(input int idx);
        chk("end_done", idx, done[idx], 1'b1);
        chk("end_busy", idx, busy[idx], 1'b0);
        chk("end_txd", idx, txd_o[idx], 1'b1);
        @(negedge clk);
        check_idle("after_end", idx);
    endtask

    initial begin
        logic [7:0] b;
        int idx;

        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start[i] = 1'b1;
            data[i]  = 8'hC3;
        end

        // Reset held with requests pending.
        repeat (3) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) check_idle("reset", i);
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) start[i] = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) check_idle("post_reset", i);

        // 0xA5 on each configuration.
        for (int i = 0; i < 3; i++) begin
            send(i, 8'hA5);
            expect_frame(i, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0);
            end_idle(i);
        end

        // Request while busy is ignored.
        send(0, 8'h0F);
        expect_frame(0, 8'h0F, 1'b0, 1'b1, 8'hFF, 1'b0);
        end_idle(0);
        repeat (CPB) begin
            @(negedge clk);
            check_idle("no_second", 0);
        end

        // txStart held high: two contiguous frames.
        start[0] = 1'b1;
        data[0]  = 8'h12;
        @(negedge clk);
        data[0]  = 8'h34;
        expect_frame(0, 8'h12, 1'b0, 1'b0, 8'h00, 1'b0);
        start[0] = 1'b0;
        expect_frame(0, 8'h34, 1'b1, 1'b0, 8'h00, 1'b1);
        end_idle(0);

        // Reset during data bit 3, then a clean frame.
        send(1, 8'h3C);
        for (int c = 0; c < 4 * CPB + 1; c++) begin
            chk("pre_rst_txd", 1, txd_o[1], exp_txd(8'h3C, PAR_OF[1], c));
            @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        check_idle("mid_reset", 1);
        reset = 1'b0;
        @(negedge clk);
        check_idle("mid_reset_rel", 1);
        send(1, 8'h55);
        expect_frame(1, 8'h55, 1'b1, 1'b0, 8'h00, 1'b0);
        end_idle(1);

        // Random bytes, configurations and mid-frame intrusions.
        for (int i = 0; i < 8; i++) begin
            idx = int'($urandom_range(0, 2));
            b   = 8'($urandom);
            send(idx, b);
            expect_frame(idx, b, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom), 1'b0);
            end_idle(idx);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
